// File: rtl/pi_loop_filter_gs.sv
// PI loop filter: signed phase error -> unsigned DCO word, gain-scheduled ACQ/TRACK with hysteretic lock.
// Latency: 1 cycle from sample_en strobe to dco_ctrl/sat_flag/mode/lock_detect update.
// No backpressure: sample_en is a one-cycle strobe; all state holds while it is low. Option macro: LF_SAT_CNT_EN.
module pi_loop_filter_gs #(
    parameter int ERR_W   = 4,
    parameter int CTRL_W  = 32,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic [ERR_W-1:0]   error_in,
    input  logic               freeze,
    input  logic [SHIFT_W-1:0] kp_shift_acq,
    input  logic [SHIFT_W-1:0] ki_shift_acq,
    input  logic [SHIFT_W-1:0] kp_shift_trk,
    input  logic [SHIFT_W-1:0] ki_shift_trk,
    input  logic [ERR_W-1:0]   lock_tol,
    input  logic [CNT_W-1:0]   lock_count,
    input  logic [CNT_W-1:0]   unlock_count,
    input  logic [CTRL_W-1:0]  initial_freq,
    output logic [CTRL_W-1:0]  dco_ctrl,
    output logic               lock_detect,
    output logic               mode,
    output logic               sat_flag
`ifdef LF_SAT_CNT_EN
    ,
    output logic [15:0]        sat_count
`endif
);

    // IW holds the shifted error; one extra bit keeps int+term sums exact before clamping.
    localparam int IW = CTRL_W + 2;
    localparam int SW = IW + 1;
    localparam logic [CTRL_W-1:0] CTRL_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {ST_ACQ = 1'b0, ST_TRACK = 1'b1} state_t;

    state_t            state_q;
    logic [CTRL_W-1:0] int_q, int_d;
    logic [CTRL_W-1:0] dco_q, dco_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  in_cnt_q, out_cnt_q;
    logic              mode_q, lock_q;

    logic [SHIFT_W-1:0] kp_sel, ki_sel;
    logic [IW-1:0]      err_ext, prop, integ;
    logic [SW-1:0]      isum, osum;
    logic               int_clamp, out_clamp;
    logic [ERR_W:0]     err_wide, err_abs;
    logic               in_tol;
    logic [CNT_W-1:0]   lock_thr, unlock_thr;
    logic [CNT_W:0]     in_next, out_next;
    logic               lock_hit, unlock_hit;

    // Gain-scheduled proportional/integral paths with clamping to the DCO word range.
    always_comb begin
        kp_sel    = (state_q == ST_TRACK) ? kp_shift_trk : kp_shift_acq;
        ki_sel    = (state_q == ST_TRACK) ? ki_shift_trk : ki_shift_acq;
        err_ext   = {{(IW-ERR_W){error_in[ERR_W-1]}}, error_in};
        prop      = $signed(err_ext) <<< kp_sel;
        integ     = $signed(err_ext) <<< ki_sel;
        isum      = {3'b000, int_q} + {integ[IW-1], integ};
        int_d     = int_q;
        int_clamp = 1'b0;
        // Frozen integrator skips its own clamp entirely.
        if (!freeze) begin
            if (isum[SW-1]) begin
                int_d     = '0;
                int_clamp = 1'b1;
            end else if (|isum[SW-2:CTRL_W]) begin
                int_d     = CTRL_MAX;
                int_clamp = 1'b1;
            end else begin
                int_d = isum[CTRL_W-1:0];
            end
        end
        osum      = {3'b000, int_d} + {prop[IW-1], prop};
        out_clamp = 1'b0;
        if (osum[SW-1]) begin
            dco_d     = '0;
            out_clamp = 1'b1;
        end else if (|osum[SW-2:CTRL_W]) begin
            dco_d     = CTRL_MAX;
            out_clamp = 1'b1;
        end else begin
            dco_d = osum[CTRL_W-1:0];
        end
        sat_d = int_clamp | out_clamp;
    end

    // Tolerance test and counter thresholds; |err| is one bit wider so the most negative code is exact.
    always_comb begin
        err_wide   = {error_in[ERR_W-1], error_in};
        err_abs    = err_wide[ERR_W] ? (~err_wide + 1'b1) : err_wide;
        in_tol     = (err_abs <= {1'b0, lock_tol});
        lock_thr   = (lock_count   == '0) ? CNT_W'(1) : lock_count;
        unlock_thr = (unlock_count == '0) ? CNT_W'(1) : unlock_count;
        in_next    = {1'b0, in_cnt_q}  + 1'b1;
        out_next   = {1'b0, out_cnt_q} + 1'b1;
        lock_hit   = (in_next  >= {1'b0, lock_thr});
        unlock_hit = (out_next >= {1'b0, unlock_thr});
    end

    // Filter state plus ACQ/TRACK FSM; everything advances only on a sample strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACQ;
            int_q     <= initial_freq;
            dco_q     <= initial_freq;
            sat_q     <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mode_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else if (sample_en) begin
            int_q <= int_d;
            dco_q <= dco_d;
            sat_q <= sat_d;
            case (state_q)
                ST_ACQ: begin
                    if (in_tol) begin
                        if (lock_hit) begin
                            state_q   <= ST_TRACK;
                            mode_q    <= 1'b1;
                            lock_q    <= 1'b1;
                            in_cnt_q  <= '0;
                            out_cnt_q <= '0;
                        end else if (in_cnt_q != CNT_MAX) begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                        end
                    end else begin
                        in_cnt_q <= '0;
                    end
                end
                ST_TRACK: begin
                    if (!in_tol) begin
                        if (unlock_hit) begin
                            state_q   <= ST_ACQ;
                            mode_q    <= 1'b0;
                            lock_q    <= 1'b0;
                            in_cnt_q  <= '0;
                            out_cnt_q <= '0;
                        end else if (out_cnt_q != CNT_MAX) begin
                            out_cnt_q <= out_cnt_q + 1'b1;
                        end
                    end else begin
                        out_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_ACQ;
            endcase
        end
    end

`ifdef LF_SAT_CNT_EN
    logic [15:0] sat_count_q;
    logic        enter_track;
    assign enter_track = (state_q == ST_ACQ) && in_tol && lock_hit;

    // Saturating count of clamped samples, restarted whenever lock is (re)acquired.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_q <= '0;
        end else if (sample_en) begin
            if (enter_track) begin
                sat_count_q <= '0;
            end else if (sat_d && (sat_count_q != 16'hFFFF)) begin
                sat_count_q <= sat_count_q + 1'b1;
            end
        end
    end

    assign sat_count = sat_count_q;
`endif

    assign dco_ctrl    = dco_q;
    assign mode        = mode_q;
    assign lock_detect = lock_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_pi_loop_filter_gs.sv
// Bench for pi_loop_filter_gs: directed scenarios plus randomized strobes vs. an arithmetic reference model.
// Outputs are sampled 1 time unit after the active clock edge.
// Stimulus is fully bench-timed; no open-ended waits on the DUT.
module tb_pi_loop_filter_gs;

    localparam int ERR_W   = 4;
    localparam int CTRL_W  = 32;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 6;
    localparam int IW      = CTRL_W + 2;
    localparam longint CMAXV = (longint'(1) << CTRL_W) - 1;
    localparam int     KMAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_en = 1'b0;
    logic [ERR_W-1:0]   error_in = '0;
    logic               freeze = 1'b0;
    logic [SHIFT_W-1:0] kp_shift_acq = '0, ki_shift_acq = '0, kp_shift_trk = '0, ki_shift_trk = '0;
    logic [ERR_W-1:0]   lock_tol = '0;
    logic [CNT_W-1:0]   lock_count = '0, unlock_count = '0;
    logic [CTRL_W-1:0]  initial_freq = '0;
    logic [CTRL_W-1:0]  dco_ctrl;
    logic               lock_detect, mode, sat_flag;
`ifdef LF_SAT_CNT_EN
    logic [15:0]        sat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    longint m_int, m_dco;
    int     m_mode, m_sat, m_in, m_out, m_satcnt;

    pi_loop_filter_gs #(
        .ERR_W(ERR_W), .CTRL_W(CTRL_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .error_in(error_in), .freeze(freeze),
        .kp_shift_acq(kp_shift_acq), .ki_shift_acq(ki_shift_acq),
        .kp_shift_trk(kp_shift_trk), .ki_shift_trk(ki_shift_trk),
        .lock_tol(lock_tol), .lock_count(lock_count), .unlock_count(unlock_count),
        .initial_freq(initial_freq), .dco_ctrl(dco_ctrl), .lock_detect(lock_detect),
        .mode(mode), .sat_flag(sat_flag)
`ifdef LF_SAT_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Value of v as seen in a two's-complement register IW bits wide.
    function automatic longint wrap_iw(input longint v);
        longint m;
        longint r;
        m = longint'(1) << IW;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint clamp_ctrl(input longint v, inout int hit);
        if (v < 0) begin
            hit = 1;
            return 0;
        end
        if (v > CMAXV) begin
            hit = 1;
            return CMAXV;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_int    = longint'(initial_freq);
        m_dco    = longint'(initial_freq);
        m_mode   = 0;
        m_sat    = 0;
        m_in     = 0;
        m_out    = 0;
        m_satcnt = 0;
    endtask

    task automatic model_sample(input int e, input bit frz);
        int     kp, ki, hit, mag, lc, uc, entered;
        longint ni;
        kp  = m_mode ? int'(kp_shift_trk) : int'(kp_shift_acq);
        ki  = m_mode ? int'(ki_shift_trk) : int'(ki_shift_acq);
        hit = 0;
        ni  = frz ? m_int : clamp_ctrl(m_int + wrap_iw(longint'(e) << ki), hit);
        m_dco = clamp_ctrl(ni + wrap_iw(longint'(e) << kp), hit);
        m_int = ni;
        m_sat = hit;
        mag = (e < 0) ? -e : e;
        lc  = (lock_count == 0) ? 1 : int'(lock_count);
        uc  = (unlock_count == 0) ? 1 : int'(unlock_count);
        entered = 0;
        if (m_mode == 0) begin
            if (mag <= int'(lock_tol)) begin
                if (m_in + 1 >= lc) begin
                    m_mode = 1; m_in = 0; m_out = 0; entered = 1;
                end else m_in = (m_in < KMAX) ? m_in + 1 : KMAX;
            end else m_in = 0;
        end else begin
            if (mag > int'(lock_tol)) begin
                if (m_out + 1 >= uc) begin
                    m_mode = 0; m_in = 0; m_out = 0;
                end else m_out = (m_out < KMAX) ? m_out + 1 : KMAX;
            end else m_out = 0;
        end
        if (entered != 0) m_satcnt = 0;
        else if (hit != 0 && m_satcnt < 65535) m_satcnt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dco"},  64'(dco_ctrl),    64'(m_dco));
        chk({tag, ".mode"}, 64'(mode),        64'(m_mode));
        chk({tag, ".lock"}, 64'(lock_detect), 64'(m_mode));
        chk({tag, ".sat"},  64'(sat_flag),    64'(m_sat));
`ifdef LF_SAT_CNT_EN
        chk({tag, ".satcnt"}, 64'(sat_count), 64'(m_satcnt));
`endif
    endtask

    task automatic strobe(input int e, input bit frz, input string tag);
        @(negedge clk);
        error_in  = ERR_W'(e);
        freeze    = frz;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        model_sample(e, frz);
        check_all(tag);
    endtask

    task automatic do_reset(input bit with_en, input int e);
        @(negedge clk);
        rst       = 1'b1;
        sample_en = with_en;
        error_in  = ERR_W'(e);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sample_en = 1'b0;
        model_reset();
        check_all("rst");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        check_all("idle");
    endtask

    task automatic rand_config();
        kp_shift_acq = SHIFT_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10));
        ki_shift_acq = SHIFT_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10));
        kp_shift_trk = SHIFT_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8));
        ki_shift_trk = SHIFT_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8));
        lock_tol     = ERR_W'($urandom_range(0, 15));
        lock_count   = CNT_W'($urandom_range(0, 5));
        unlock_count = CNT_W'($urandom_range(0, 5));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int seq_lock[8]   = '{0, 1, -1, 3, 0, 0, 1, 0};
        int seq_unlock[6] = '{5, 5, 0, 5, 5, 5};
        int r;

        // reset and hold
        initial_freq = 32'h1000_0000;
        kp_shift_acq = 5'd4; ki_shift_acq = 5'd1;
        kp_shift_trk = 5'd0; ki_shift_trk = 5'd0;
        lock_tol = 4'd0; lock_count = 6'd60; unlock_count = 6'd1;
        do_reset(1'b0, 0);
        chk("rst_dco", 64'(dco_ctrl), 64'h1000_0000);
        chk("rst_sat", 64'(sat_flag), 64'h0);
        idle(10);
        chk("hold_dco", 64'(dco_ctrl), 64'h1000_0000);

        // gain path and integrator value
        strobe(3, 1'b0, "gain");
        chk("gain_dco", 64'(dco_ctrl), 64'h1000_0036);
        strobe(0, 1'b0, "gain_int");
        chk("int_val", 64'(dco_ctrl), 64'h1000_0006);
        do_reset(1'b0, 0);
        strobe(3, 1'b1, "frz");
        chk("frz_dco", 64'(dco_ctrl), 64'h1000_0030);

        // lock entry with a count restart
        do_reset(1'b0, 0);
        lock_tol = 4'd1; lock_count = 6'd4;
        for (int i = 0; i < 8; i++) begin
            strobe(seq_lock[i], 1'b0, "lockseq");
            if (i == 6) chk("pre_lock_mode", 64'(mode), 64'h0);
        end
        chk("lock_mode", 64'(mode), 64'h1);
        chk("lock_det", 64'(lock_detect), 64'h1);

        // unlock hysteresis
        unlock_count = 6'd3;
        for (int i = 0; i < 6; i++) begin
            strobe(seq_unlock[i], 1'b0, "unlockseq");
            if (i == 4) chk("pre_unlock_mode", 64'(mode), 64'h1);
        end
        chk("unlock_mode", 64'(mode), 64'h0);

        // saturation at both rails
        kp_shift_acq = 5'd0; ki_shift_acq = 5'd0;
        initial_freq = 32'hFFFF_FFFE;
        do_reset(1'b0, 0);
        strobe(3, 1'b0, "sat_hi");
        chk("sat_hi_dco", 64'(dco_ctrl), 64'hFFFF_FFFF);
        chk("sat_hi_flag", 64'(sat_flag), 64'h1);
        initial_freq = 32'h0000_0001;
        do_reset(1'b0, 0);
        strobe(-8, 1'b0, "sat_lo");
        chk("sat_lo_dco", 64'(dco_ctrl), 64'h0);
        chk("sat_lo_flag", 64'(sat_flag), 64'h1);
        strobe(0, 1'b0, "sat_clr");
        chk("sat_clr_flag", 64'(sat_flag), 64'h0);

        // reset coincident with a strobe mid-TRACK, then counter clearing in ACQ
        initial_freq = 32'h1000_0000;
        kp_shift_acq = 5'd4; ki_shift_acq = 5'd1;
        do_reset(1'b0, 0);
        lock_count = 6'd1;
        strobe(0, 1'b0, "trk_in");
        chk("trk_mode", 64'(mode), 64'h1);
        strobe(5, 1'b0, "trk_out");
        do_reset(1'b1, 5);
        chk("rst_trk_dco", 64'(dco_ctrl), 64'h1000_0000);
        chk("rst_trk_mode", 64'(mode), 64'h0);
        lock_count = 6'd4;
        strobe(0, 1'b0, "cnt_a");
        strobe(0, 1'b0, "cnt_b");
        do_reset(1'b1, 0);
        strobe(0, 1'b0, "cnt_c");
        strobe(0, 1'b0, "cnt_d");
        chk("cnt_cleared_mode", 64'(mode), 64'h0);

        // randomized traffic against the model
        rand_config();
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                case ($urandom_range(0, 2))
                    0:       initial_freq = CTRL_W'($urandom);
                    1:       initial_freq = CTRL_W'($urandom_range(0, 20));
                    default: initial_freq = CTRL_W'(32'hFFFF_FFFF - $urandom_range(0, 20));
                endcase
                do_reset(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)) - 8);
            end else if (r < 6) begin
                idle(int'($urandom_range(1, 3)));
            end else if (r < 12) begin
                rand_config();
            end else begin
                strobe(int'($urandom_range(0, 15)) - 8, ($urandom_range(0, 3) == 0), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pi_loop_filter_gs.md
Name: pi_loop_filter_gs

Overview:
Parametrised PI loop filter for the all-digital PLL, sitting between the phase detector and the DCO. It converts signed phase error into an unsigned DCO control word. Over the first-generation filter it adds configurable widths, output/integrator saturation, an integrator freeze input, and a two-state acquire/track FSM with gain scheduling and hysteretic lock detection.

Parameters:
ERR_W, 4, width of signed error_in
CTRL_W, 32, width of unsigned DCO control word
SHIFT_W, 5, width of gain shift fields
CNT_W, 6, width of lock/unlock counters and thresholds

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
sample_en  input  1  one-cycle strobe; error_in valid
error_in  input  ERR_W  signed phase error
freeze  input  1  hold integrator (proportional path still active)
kp_shift_acq  input  SHIFT_W  proportional shift, ACQ state
ki_shift_acq  input  SHIFT_W  integral shift, ACQ state
kp_shift_trk  input  SHIFT_W  proportional shift, TRACK state
ki_shift_trk  input  SHIFT_W  integral shift, TRACK state
lock_tol  input  ERR_W  max |error| counted as in-tolerance (unsigned)
lock_count  input  CNT_W  consecutive in-tol samples to enter TRACK
unlock_count  input  CNT_W  consecutive out-of-tol samples to leave TRACK
initial_freq  input  CTRL_W  reset value of integrator and dco_ctrl
dco_ctrl  output  CTRL_W  registered DCO control word
lock_detect  output  1  high while in TRACK
mode  output  1  0=ACQ, 1=TRACK
sat_flag  output  1  last processed sample hit a clamp

Behaviour:
- Everything is synchronous to clk. rst has priority over all other inputs. On rst: integrator=dco_ctrl=initial_freq, mode=ACQ, lock_detect=0, sat_flag=0, both counters=0.
- sample_en=0: all state and outputs hold.
- Arithmetic width: IW=CTRL_W+2 signed. Error is sign-extended to IW. prop = ext(err) <<< kp, integ = ext(err) <<< ki, truncated to IW. The kp/ki pair is selected by the current state, so the sample that triggers a transition still uses the old state's gains.
- Integrator update:
  - ni = clamp(int + integ) to [0, 2^CTRL_W-1].
  - If freeze=1, ni = int and no integral clamp is evaluated.
  - no = clamp(ni + prop), same range.
  - On sample_en: int<=ni and dco_ctrl<=no. New values are visible the cycle after the strobe (latency 1).
- sat_flag: updated on every sample; 1 if either clamp engaged on that sample, else 0.
- |err| is computed in ERR_W+1 bits, so the most negative input (-8 at ERR_W=4) gives 8. in_tol = |err| <= lock_tol.
- FSM (advances only on sample_en). lock_count=0 and unlock_count=0 behave as 1. Counters saturate at 2^CNT_W-1.
  - ACQ: in_tol increments in_cnt; otherwise in_cnt<=0. When in_cnt+1 >= lock_count on an in_tol sample: go to TRACK, in_cnt<=0, out_cnt<=0.
  - TRACK: !in_tol increments out_cnt; in_tol sets out_cnt<=0. When out_cnt+1 >= unlock_count on an out-of-tol sample: go to ACQ, both counters<=0.
- mode and lock_detect are registered state outputs and change the cycle after the triggering strobe.
- freeze does not affect the FSM.

Optional Feature:
LF_SAT_CNT_EN: when defined, adds output sat_count [15:0]. It increments (saturating at 0xFFFF) on each sample with sat_flag set, and clears on rst and on every ACQ->TRACK transition. When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Reset: initial_freq=0x1000_0000, rst pulse -> dco_ctrl=0x1000_0000, mode=0, lock_detect=0, sat_flag=0; sample_en=0 for 10 cycles -> no change.
- Gain path: ACQ, kp_acq=4, ki_acq=1, err=+3 single strobe -> next cycle dco_ctrl=0x1000_0000+6+48=0x1000_0036, integrator 0x1000_0006; freeze=1 with same stimulus -> dco_ctrl=0x1000_0000+48.
- Lock entry: lock_tol=1, lock_count=4, err sequence 0,1,-1,3,0,0,1,0 -> 3 resets the count; mode=1 one cycle after the 8th strobe, and that strobe used acq shifts.
- Unlock hysteresis: in TRACK, unlock_count=3, err 5,5,0,5,5,5 -> mode stays 1 until the cycle after the 6th strobe, then 0.
- Saturation: initial_freq=2^CTRL_W-2, ki=kp=0, err=+3 -> dco_ctrl=2^CTRL_W-1, sat_flag=1; initial_freq=1, err=-8 (min value, |err|=8) -> dco_ctrl=0, sat_flag=1; next err=0 -> sat_flag=0.
- rst asserted coincident with sample_en mid-TRACK -> reset values win, counters cleared; with LF_SAT_CNT_EN, sat_count=0.
